alu_issue_stage: RTL

- ID/EX issue register for the pipelined RISC-V core; the producing end of the ALU's select/operand interface.
- Decodes ALUOp/funct3/funct7[5] into the 3-bit ALU select, muxes operand B (register or immediate), and registers select plus operands for the EX stage.
- Handles stall (hold), flush (bubble) and illegal-op flagging.
- Keeps a saturating count of issued ALU operations for debug.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_op_decoder.sv | 33 +++
 rtl/alu_issue_stage.sv | 81 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings for the decode and issue stages.
//   ALU select codes, ALUOp codes from the main decoder, funct3 codes for
//   the ALU ops this core implements.
package alu_pkg;

  // ALU select (ex_sl)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // ALUOp from the main decoder
  localparam logic [1:0] AOP_ADD = 2'b00;  // load/store/jalr address
  localparam logic [1:0] AOP_SUB = 2'b01;  // branch compare
  localparam logic [1:0] AOP_R   = 2'b10;  // R-type
  localparam logic [1:0] AOP_I   = 2'b11;  // I-type ALU

  // funct3
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU op decoder.
//   alu_op, funct3, funct7_5 -> sel (ALU select), illegal (unsupported op).
//   Unsupported funct3 on R/I-type yields sel = add with illegal set.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] sel,
  output logic       illegal
);

  always_comb begin
    sel     = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      AOP_ADD: sel = ALU_ADD;
      AOP_SUB: sel = ALU_SUB;
      default: begin
        case (funct3)
          // I-type has no sub; bit 30 there is part of the immediate
          F3_ADD:  sel = (alu_op == AOP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          F3_SLT:  sel = ALU_SLT;
          F3_OR:   sel = ALU_OR;
          F3_AND:  sel = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the ALU.
//   Inputs : clk, rst (async, active-high), id_* decode fields and operands,
//            stall (hold EX), flush (bubble EX).
//   Outputs: ex_valid, ex_sl, ex_ain, ex_bin, ex_illegal (registered, one
//            cycle after ID), ex_issue_cnt (saturating count of legal ops).
//   Priority per edge: flush > stall > bubble (id_valid=0) > load.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       id_alu_op,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_5,
  input  logic             id_alu_src,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [2:0]       ex_sl,
  output logic [XLEN-1:0]  ex_ain,
  output logic [XLEN-1:0]  ex_bin,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] ex_issue_cnt
);

  logic [2:0]      dec_sl;
  logic            dec_ill;
  logic [XLEN-1:0] opb;
  logic            load;

  alu_op_decoder u_dec (
    .alu_op   (id_alu_op),
    .funct3   (id_funct3),
    .funct7_5 (id_funct7_5),
    .sel      (dec_sl),
    .illegal  (dec_ill)
  );

  assign opb  = id_alu_src ? id_imm : id_rs2_data;
  assign load = !flush && !stall && id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_sl      <= ALU_ADD;
      ex_ain     <= '0;
      ex_bin     <= '0;
      ex_illegal <= 1'b0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid   <= 1'b0;
      ex_sl      <= ALU_ADD;
      ex_ain     <= '0;
      ex_bin     <= '0;
      ex_illegal <= 1'b0;
    end else if (load) begin
      ex_valid   <= 1'b1;
      ex_sl      <= dec_sl;
      // Illegal ops present zero operands so the ALU result is 0, same as
      // a bubble; consumers qualify with ex_illegal.
      ex_ain     <= dec_ill ? '0 : id_rs1_data;
      ex_bin     <= dec_ill ? '0 : opb;
      ex_illegal <= dec_ill;
    end
  end

  // Debug counter: survives flush, cleared only by reset, sticks at max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ex_issue_cnt <= '0;
    else if (load && !dec_ill && (ex_issue_cnt != {CNT_W{1'b1}}))
      ex_issue_cnt <= ex_issue_cnt + 1'b1;
  end

endmodule
